sdram_burst_responder: RTL
==========================

# sdram_burst_responder

Avalon-MM burst slave that stands in for the SDRAM controller behind the register-file load/store engine. It accepts 128-bit read and write bursts (11 beats = one 176-byte RF line), backs them with an on-chip word array, and returns read data through a pipelined `readdatavalid` stream. It is used for FPGA bring-up without external SDRAM and as the reference memory model in RF load/store benches.

## Interface
Parameters:
- `DATA_W`, default 128: beat width in bits; one word = `DATA_W/8` bytes.
- `MEM_W`, default 12: log2 of memory depth in words.
- `BURST_W`, default 4: width of `burstcount`.
- `WAIT_STATES`, default 0: cycles of `waitrequest` before a command is accepted; range 0–15.
- `RD_LATENCY`, default 1: cycles from a read issue to its `readdatavalid` beat; must be ≥ 1.

Ports:
- `clk`, input, 1: clock. This block has one clock.
- `rst`, input, 1: reset. Synchronous and active-high.
- `address`, input, 32: byte address. The word index is `address[MEM_W+3:4]`.
- `burstcount`, input, `BURST_W`: number of beats in the burst.
- `read`, input, 1: read command.
- `write`, input, 1: write command and write-beat strobe.
- `writedata`, input, `DATA_W`: write beat data.
- `byteenable`, input, `DATA_W/8`: per-byte write mask.
- `waitrequest`, output, 1: slave stall.
- `readdata`, output, `DATA_W`: read beat data.
- `readdatavalid`, output, 1: read beat valid.
- `busy`, output, 1: high whenever state ≠ IDLE.
- `err`, output, 1: sticky protocol-error flag.
- `err_clr`, input, 1: clears `err`.

## Operation
States: IDLE, WRITE_BURST, READ_ISSUE, READ_DRAIN.

- **IDLE**
  - `wcnt` counts consecutive cycles with `read|write` high. It resets to 0 when both are low.
  - `waitrequest = (wcnt != WAIT_STATES)`.
  - **Accept cycle:** `read|write` is high and `wcnt == WAIT_STATES`. On this cycle the block latches the word index and beat count `n = burstcount` and sets `wcnt` to 0.
  - If `burstcount == 0`, then `n = 1` and `err` is set.
- **Write accept**
  - Beat 0 is written to word index `idx` on the accept edge.
  - If `n == 1`, stay in IDLE. Otherwise go to WRITE_BURST.
- **WRITE_BURST**
  - `waitrequest = 0`.
  - Each cycle with `write = 1` writes the next word and increments the index.
  - Cycles with `write = 0` are stalls: no write and no advance.
  - After beat `n-1` is written, go to IDLE.
  - `read = 1` in this state sets `err` and is otherwise ignored.
- **Read accept**
  - The accept cycle issues the RAM read of word `idx`, then goes to READ_ISSUE. If `n == 1`, it goes straight to READ_DRAIN.
- **READ_ISSUE**
  - `waitrequest = 1`.
  - Issues one read per cycle, incrementing the index, until `n` reads have been issued in total. Then go to READ_DRAIN.
- **READ_DRAIN**
  - `waitrequest = 1`.
  - Go to IDLE on the cycle the last `readdatavalid` beat is presented.
- **Read pipeline**
  - One synchronous RAM read stage plus `RD_LATENCY-1` register stages.
  - `readdatavalid` and `readdata` are registered outputs.
  - Beats are returned in issue order with no gaps.
- **Write masking:** only bytes whose `byteenable` bit is set are updated.
- **Addressing**
  - Address bits [3:0] are ignored. If they are nonzero, `err` is set.
  - Word index arithmetic is modulo 2^`MEM_W`, so bursts wrap from the last word to word 0.
- **Simultaneous `read` and `write` at the accept cycle:** read wins and `err` is set.
- **`err`:** set by any error event and cleared by `err_clr`. If both happen in the same cycle, set wins.

## Timing
- **Reset values**
  - State = IDLE, `wcnt = 0`.
  - `readdatavalid = 0`, `readdata = 0`, `err = 0`, `busy = 0`.
  - `waitrequest = (WAIT_STATES != 0)`.
  - The memory array is not reset.
- **Accept cycle A:** the command is seen high for `WAIT_STATES+1` consecutive cycles, with `waitrequest` low only in the last of them.
- **Read burst accepted at A:** `readdatavalid` is high in cycles A+`RD_LATENCY` through A+`RD_LATENCY`+n−1.
  - The earliest next accept is the cycle after the last beat, when `WAIT_STATES = 0`.
- **Write burst:** the earliest next accept is the cycle after the final write beat.
- **Single-beat write with `WAIT_STATES = 0`:** back-to-back single-beat writes are accepted every cycle.
- **Reset mid-burst**
  - The next cycle is IDLE with `readdatavalid = 0`.
  - Pending read beats are discarded.
  - Words already written are retained.
  - A partially written burst is not completed.
- **Read-after-write:** a read accepted the cycle after a write burst's last beat returns the new data.

## Test plan
1. `WAIT_STATES = 0`, `RD_LATENCY = 1`. Write burst of 11 beats at 0x0000_0000 with data k = 0..10, then read burst of 11 at 0x0 → 11 contiguous valid beats equal to 0..10; the first beat is 1 cycle after the read accept.
2. `WAIT_STATES = 2`, `RD_LATENCY = 3`. Hold `read` at 0x0B0 → `waitrequest` is low only in the 3rd cycle; the first beat arrives 3 cycles after accept and returns word 11's data.
3. Write burst of 4 with `write` dropped for 2 cycles after beat 1 → words 0..3 hold beats 0..3; `busy` stays high through the stall; no extra word is written.
4. Pre-fill word 5 with all-ones, then write 1 beat of zeros with `byteenable = 0x00FF` → readback is 0xFFFF…FFFF_0000…0000 (upper 8 bytes ones, lower 8 bytes zero).
5. Read burst of 3 at the last word (`MEM_W = 12`, address 0xFFF0) → beats are words 4095, 0, 1; `err` stays 0. Address 0x0004 → `err = 1`; `err_clr` clears it.
6. Assert `rst` after the 4th beat of an 11-beat read → `readdatavalid = 0` from the next cycle, `busy = 0`, and a following read returns the original memory contents.

Source files
------------

// File: rtl/sdram_burst_responder_if.sv
// Avalon-MM burst bus between the RF load/store engine (master) and the
// on-chip SDRAM stand-in (slave).
interface sdram_burst_responder_if #(
   parameter int DATA_W  = 128,
   parameter int BURST_W = 4
);
   logic [31:0]         address;
   logic [BURST_W-1:0]  burstcount;
   logic                read;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic [DATA_W/8-1:0] byteenable;
   logic                waitrequest;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;

   // A command is accepted on the cycle read|write is high with waitrequest
   // low; write beats inside a burst are taken whenever write is high, and
   // readdatavalid qualifies readdata for one cycle per returned beat.
   modport master (
      output address, burstcount, read, write, writedata, byteenable,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, burstcount, read, write, writedata, byteenable,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/sdram_burst_responder.sv
// Avalon-MM burst slave backed by an on-chip word array: stands in for the
// SDRAM controller and returns read bursts through a pipelined valid stream.
module sdram_burst_responder #(
   parameter int DATA_W      = 128,
   parameter int MEM_W       = 12,
   parameter int BURST_W     = 4,
   parameter int WAIT_STATES = 0,
   parameter int RD_LATENCY  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   sdram_burst_responder_if.slave  bus,
   input  logic                    err_clr,
   output logic                    busy,
   output logic                    err,
   output logic [1:0]              dbg_state
);
   localparam int          BE_W  = DATA_W / 8;
   localparam int          DEPTH = 1 << MEM_W;
   localparam logic [3:0]  WS    = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WRITE_BURST = 2'd1,
      READ_ISSUE  = 2'd2,
      READ_DRAIN  = 2'd3
   } state_t;

   state_t             state;
   logic [3:0]         wcnt;
   logic [MEM_W-1:0]   idx;
   logic [BURST_W-1:0] left;     // write beats / read issues still to do
   logic [BURST_W-1:0] rd_out;   // read beats not yet presented

   logic [DATA_W-1:0]     mem [DEPTH];
   logic [DATA_W-1:0]     pipe_d [RD_LATENCY];
   logic [RD_LATENCY-1:0] pipe_v;

   logic               cmd;
   logic               accept;
   logic [MEM_W-1:0]   cmd_idx;
   logic [BURST_W-1:0] cmd_n;
   logic               err_set;
   logic               we;
   logic [MEM_W-1:0]   w_idx;
   logic               rd_en;
   logic [MEM_W-1:0]   r_idx;
   logic               unused_addr;

   assign cmd         = bus.read | bus.write;
   assign accept      = (state == IDLE) && cmd && (wcnt == WS);
   assign cmd_idx     = bus.address[MEM_W+3:4];
   assign cmd_n       = (bus.burstcount == '0) ? BURST_W'(1) : bus.burstcount;
   assign unused_addr = ^bus.address[31:MEM_W+4];

   assign err_set = (accept && ((bus.burstcount == '0) ||
                                (bus.address[3:0] != 4'd0) ||
                                (bus.read && bus.write))) ||
                    ((state == WRITE_BURST) && bus.read);

   assign busy      = (state != IDLE);
   assign dbg_state = state;
   assign bus.waitrequest = (state == IDLE) ? (wcnt != WS) : (state != WRITE_BURST);
   assign bus.readdata      = pipe_d[RD_LATENCY-1];
   assign bus.readdatavalid = pipe_v[RD_LATENCY-1];

   // RAM port control: the accept cycle addresses straight from the bus,
   // later beats from the running index. Read wins over a simultaneous write.
   always_comb begin
      we    = 1'b0;
      w_idx = idx;
      rd_en = 1'b0;
      r_idx = idx;
      case (state)
         IDLE: begin
            if (accept) begin
               if (bus.read) begin
                  rd_en = 1'b1;
                  r_idx = cmd_idx;
               end else begin
                  we    = 1'b1;
                  w_idx = cmd_idx;
               end
            end
         end
         WRITE_BURST: we    = bus.write;
         READ_ISSUE:  rd_en = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < BE_W; b++) begin
            if (bus.byteenable[b]) mem[w_idx][8*b +: 8] <= bus.writedata[8*b +: 8];
         end
      end
   end

   // Stage 0 is the synchronous RAM read; further stages only add latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_v <= '0;
         for (int s = 0; s < RD_LATENCY; s++) pipe_d[s] <= '0;
      end else begin
         pipe_v[0] <= rd_en;
         if (rd_en) pipe_d[0] <= mem[r_idx];
         for (int s = 1; s < RD_LATENCY; s++) begin
            pipe_v[s] <= pipe_v[s-1];
            pipe_d[s] <= pipe_d[s-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         wcnt   <= 4'd0;
         idx    <= '0;
         left   <= '0;
         rd_out <= '0;
         err    <= 1'b0;
      end else begin
         err <= err_set | (err & ~err_clr);
         if (bus.readdatavalid && (rd_out != '0)) rd_out <= rd_out - 1'b1;
         case (state)
            IDLE: begin
               if (!cmd) begin
                  wcnt <= 4'd0;
               end else if (accept) begin
                  wcnt <= 4'd0;
                  idx  <= cmd_idx + 1'b1;
                  left <= cmd_n - 1'b1;
                  if (bus.read) begin
                     rd_out <= cmd_n;
                     state  <= (cmd_n == BURST_W'(1)) ? READ_DRAIN : READ_ISSUE;
                  end else if (cmd_n != BURST_W'(1)) begin
                     state <= WRITE_BURST;
                  end
               end else begin
                  wcnt <= wcnt + 4'd1;
               end
            end
            WRITE_BURST: begin
               if (bus.write) begin
                  idx  <= idx + 1'b1;
                  left <= left - 1'b1;
                  if (left == BURST_W'(1)) state <= IDLE;
               end
            end
            READ_ISSUE: begin
               idx  <= idx + 1'b1;
               left <= left - 1'b1;
               if (left == BURST_W'(1)) state <= READ_DRAIN;
            end
            READ_DRAIN: begin
               if (bus.readdatavalid && (rd_out == BURST_W'(1))) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
